datamover_rd_engine: RTL

// MM2S read engine of the HP0 datamover, the counterpart of the S2MM write path.
// - Accepts a read command (byte address, byte length).
// - Issues AXI4 INCR read bursts on HP0 and returns the data as a 64-bit valid/ready stream.
// - Marks the final beat with last/keep and pulses finish once the command completes.
// - Sits inside datamover_ctrl, between the user read interface and the HP0 AR/R channels.

---
 rtl/datamover_pkg.sv | 29 ++
 rtl/datamover_skid.sv | 66 ++++++
 rtl/datamover_rd_engine.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/datamover_pkg.sv
// Shared types and AXI constants for the HP0 datamover read path.
package datamover_pkg;

    localparam int         BEAT_BYTES     = 8;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXSIZE_8B      = 3'd3;
    localparam logic [3:0] AXCACHE_DEF    = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } rd_state_t;

    // One stream beat as carried through the output register slice.
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } rd_beat_t;

    // Byte enables for the final beat, given the residual byte count len[2:0].
    function automatic logic [7:0] tail_keep(input logic [2:0] rem);
        tail_keep = (rem == 3'd0) ? 8'hFF : (8'hFF >> (4'd8 - {1'b0, rem}));
    endfunction

endpackage

// File: rtl/datamover_skid.sv
// Two-entry register slice: registered output, accepts a beat whenever not full,
// so a continuously ready sink sees one beat per clock.
module datamover_skid #(
    parameter int W = 73
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         push, pop;

    assign o_full  = (count_q == 2'd2);
    assign o_empty = (count_q == 2'd0);
    assign o_ready = !o_full;
    assign o_valid = !o_empty;
    assign o_data  = mem_q[rd_ptr_q];
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = i_data;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // State registers; storage is cleared too so the stream outputs read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the two data entries are reset on purpose: they drive o_rd_data directly.
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/datamover_rd_engine.sv
// MM2S read engine: turns a (byte address, byte length) command into 4KB-safe
// AXI4 INCR bursts on HP0 and streams the returned data out as 64-bit beats.
module datamover_rd_engine
    import datamover_pkg::*;
#(
    parameter int MAX_BURST_LEN = 16,
    parameter int ADDR_W        = 32,
    parameter int LEN_W         = 23
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_rd_cmd_addr,
    input  logic [LEN_W-1:0]  i_rd_cmd_length,
    input  logic              i_rd_cmd_req,
    output logic              o_rd_cmd_ack,
    input  logic              i_rd_ready,
    output logic              o_rd_valid,
    output logic [63:0]       o_rd_data,
    output logic [7:0]        o_rd_keep,
    output logic              o_rd_last,
    output logic              o_read_finish,
    output logic              o_rd_err,
    input  logic              hp0_arready,
    output logic              hp0_arvalid,
    output logic [3:0]        hp0_arid,
    output logic [ADDR_W-1:0] hp0_araddr,
    output logic [7:0]        hp0_arlen,
    output logic [2:0]        hp0_arsize,
    output logic [1:0]        hp0_arburst,
    output logic [2:0]        hp0_arprot,
    output logic [3:0]        hp0_arcache,
    input  logic [63:0]       hp0_rdata,
    input  logic [1:0]        hp0_rresp,
    input  logic              hp0_rlast,
    input  logic              hp0_rvalid,
    output logic              hp0_rready
);

    localparam int BL_W = LEN_W - 2;

    rd_state_t         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BL_W-1:0]   beats_left_q, beats_left_d;
    logic [8:0]        burst_q, burst_d;
    logic [8:0]        beat_cnt_q, beat_cnt_d;
    logic [7:0]        keep_last_q, keep_last_d;
    logic              ack_q, ack_d;
    logic              finish_q, finish_d;
    logic              err_q, err_d;

    logic [12:0]       dist_bytes;
    logic [9:0]        dist_beats;
    logic [BL_W-1:0]   lim;
    logic [8:0]        burst;
    logic [8:0]        cnt_next;
    logic              final_burst;
    logic              in_data;
    logic              r_hs;
    logic              skid_ready, skid_full, skid_empty;
    rd_beat_t          beat_in, beat_out;

    // Burst size: smallest of remaining beats, the burst cap and the distance to the 4KB boundary.
    always_comb begin
        dist_bytes = 13'd4096 - {1'b0, addr_q[11:0]};
        dist_beats = 10'(dist_bytes >> 3);
        lim        = beats_left_q;
        if (lim > BL_W'(MAX_BURST_LEN)) lim = BL_W'(MAX_BURST_LEN);
        if (lim > BL_W'(dist_beats))    lim = BL_W'(dist_beats);
        burst = 9'(lim);
    end

    assign final_burst = (beats_left_q == '0);
    assign in_data     = (state_q == ST_DATA);
    assign hp0_rready  = in_data && !skid_full;
    assign r_hs        = hp0_rvalid && in_data && skid_ready;
    assign cnt_next    = beat_cnt_q + 9'd1;

    // Beat entering the slice: last/keep only on the final beat of the final burst.
    always_comb begin
        beat_in.data = hp0_rdata;
        beat_in.last = hp0_rlast && final_burst;
        beat_in.keep = beat_in.last ? keep_last_q : 8'hFF;
    end

    // FSM next-state plus command, counter and status updates.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        beats_left_d = beats_left_q;
        burst_d      = burst_q;
        beat_cnt_d   = beat_cnt_q;
        keep_last_d  = keep_last_q;
        ack_d        = 1'b0;
        finish_d     = 1'b0;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (i_rd_cmd_req) begin
                    addr_d       = i_rd_cmd_addr & ~ADDR_W'(BEAT_BYTES - 1);
                    beats_left_d = BL_W'(i_rd_cmd_length >> 3) + BL_W'(|i_rd_cmd_length[2:0]);
                    keep_last_d  = tail_keep(i_rd_cmd_length[2:0]);
                    ack_d        = 1'b1;
                    err_d        = 1'b0;
                    state_d      = (i_rd_cmd_length == '0) ? ST_DONE : ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (hp0_arready) begin
                    addr_d       = addr_q + ADDR_W'(burst) * ADDR_W'(BEAT_BYTES);
                    beats_left_d = beats_left_q - BL_W'(burst);
                    burst_d      = burst;
                    beat_cnt_d   = 9'd0;
                    state_d      = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_hs) begin
                    beat_cnt_d = cnt_next;
                    if (hp0_rresp != AXI_RESP_OKAY) err_d = 1'b1;
                    // rlast is trusted for sequencing; disagreement with our count is only flagged.
                    if (hp0_rlast != (cnt_next == burst_q)) err_d = 1'b1;
                    if (hp0_rlast) state_d = final_burst ? ST_DONE : ST_ADDR;
                end
            end
            ST_DONE: begin
                if (skid_empty) begin
                    finish_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            beats_left_q <= '0;
            burst_q      <= 9'd0;
            beat_cnt_q   <= 9'd0;
            keep_last_q  <= 8'h00;
            ack_q        <= 1'b0;
            finish_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            burst_q      <= burst_d;
            beat_cnt_q   <= beat_cnt_d;
            keep_last_q  <= keep_last_d;
            ack_q        <= ack_d;
            finish_q     <= finish_d;
            err_q        <= err_d;
        end
    end

    // AR channel is a direct decode of the ADDR state, so it drops with reset immediately.
    assign hp0_arvalid = (state_q == ST_ADDR);
    assign hp0_araddr  = hp0_arvalid ? addr_q : '0;
    assign hp0_arlen   = hp0_arvalid ? 8'(burst - 9'd1) : 8'h00;
    assign hp0_arsize  = hp0_arvalid ? AXSIZE_8B : 3'd0;
    assign hp0_arburst = hp0_arvalid ? AXI_BURST_INCR : 2'b00;
    assign hp0_arcache = hp0_arvalid ? AXCACHE_DEF : 4'b0000;
    assign hp0_arid    = 4'd0;
    assign hp0_arprot  = 3'd0;

    datamover_skid #(
        .W($bits(rd_beat_t))
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_valid(hp0_rvalid && in_data),
        .o_ready(skid_ready),
        .i_data (beat_in),
        .o_valid(o_rd_valid),
        .i_ready(i_rd_ready),
        .o_data (beat_out),
        .o_full (skid_full),
        .o_empty(skid_empty)
    );

    assign o_rd_data     = beat_out.data;
    assign o_rd_keep     = beat_out.keep;
    assign o_rd_last     = beat_out.last;
    assign o_rd_cmd_ack  = ack_q;
    assign o_read_finish = finish_q;
    assign o_rd_err      = err_q;

endmodule
